// File: rtl/program_loader.sv
// program_loader: receives a framed program image over a byte stream and
// writes it word by word into program memory, holding the core in reset
// until a load completes with a good checksum.
//
// Frame: SYNC_BYTE, LEN_LO, LEN_HI (word count N), 4*N payload bytes
// (each word LSB first), then one checksum byte (XOR of the payload).
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset      - synchronous active-low reset
//   rx_valid   - upstream presents a byte
//   rx_data    - byte value
//   rx_ready   - loader accepts a byte this cycle (low only while writing)
//   mem_we     - program-memory write strobe (one cycle per word)
//   mem_addr   - program-memory word address
//   mem_wdata  - instruction word being written
//   cpu_hold   - hold the core in reset (low only after a good load)
//   done       - load completed with a good checksum
//   error      - load aborted (bad length or bad checksum)
module program_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    // Memory capacity in words, wide enough to hold 2^ADDR_W itself.
    localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERR
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          len_lo_q, len_lo_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         word_q, word_d;
    logic [7:0]          csum_q, csum_d;
    logic [1:0]          bcnt_q, bcnt_d;

    logic                rdy_q;
    logic                we_q;
    logic                hold_q;
    logic                done_q;
    logic                err_q;

    logic                accept;
    logic                is_sync;
    logic [15:0]         n_full;
    logic                too_long;
    logic [15:0]         cnt_inc;

    assign accept   = rx_valid & rdy_q;
    assign is_sync  = (rx_data == SYNC_BYTE);
    assign n_full   = {rx_data, len_lo_q};
    assign too_long = (33'(n_full) > MAX_WORDS);
    assign cnt_inc  = cnt_q + 16'd1;

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        word_d   = word_q;
        csum_d   = csum_q;
        bcnt_d   = bcnt_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                // A sync byte starts (or restarts) a load from a clean slate.
                if (accept && is_sync) begin
                    state_d = LEN_LO;
                    addr_d  = '0;
                    cnt_d   = '0;
                    csum_d  = '0;
                    bcnt_d  = '0;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_lo_d = rx_data;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d  = n_full;
                    bcnt_d = '0;
                    if (too_long) begin
                        state_d = ERR;
                    end else if (n_full == 16'd0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                // Bytes arrive LSB first, so shift in from the top.
                if (accept) begin
                    word_d = {rx_data, word_q[31:8]};
                    csum_d = csum_q ^ rx_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                // Termination uses the word count, not address wrap.
                addr_d = addr_q + ADDR_W'(1);
                cnt_d  = cnt_inc;
                if (cnt_inc == len_q) begin
                    state_d = CHECK;
                end else begin
                    state_d = DATA;
                end
            end
            CHECK: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? DONE : ERR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; outputs are registered from the next state so they
    // line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            len_lo_q <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            word_q   <= '0;
            csum_q   <= '0;
            bcnt_q   <= '0;
            rdy_q    <= 1'b1;
            we_q     <= 1'b0;
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            word_q   <= word_d;
            csum_q   <= csum_d;
            bcnt_q   <= bcnt_d;
            rdy_q    <= (state_d != WRITE);
            we_q     <= (state_d == WRITE);
            hold_q   <= (state_d != DONE);
            done_q   <= (state_d == DONE);
            err_q    <= (state_d == ERR);
        end
    end

    assign rx_ready  = rdy_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = word_q;
    assign cpu_hold  = hold_q;
    assign done      = done_q;
    assign error     = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: drives framed byte streams and checks the
// memory writes against a scoreboard of expected (address, word) pairs.
module tb_program_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    program_loader #(
        .ADDR_W    (ADDR_W),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] img [DEPTH];
    logic [31:0] words[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        prev_we  = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: pops the scoreboard on every strobe.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            check_eq("rdy_low_in_write", 64'(rx_ready), 64'd0);
            check_eq("we_single_cycle", 64'(prev_we), 64'd0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("wr_addr", 64'(mem_addr), 64'(mon_e.addr));
                check_eq("wr_data", 64'(mem_wdata), 64'(mon_e.data));
            end
            img[mem_addr] = mem_wdata;
        end
        prev_we = mem_we;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    // Present one byte from a negedge; returns on the negedge after it is taken.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check_eq("rx_ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    // Sends the whole frame built from 'words', scoreboarding each write.
    task automatic send_frame(input bit bad_ck);
        logic [7:0]  ck  = 8'h00;
        logic [15:0] n16 = 16'(words.size());
        logic [31:0] w;
        wr_t         e;
        send_byte(8'hA5);
        send_byte(n16[7:0]);
        send_byte(n16[15:8]);
        for (int i = 0; i < words.size(); i++) begin
            w      = words[i];
            e.addr = ADDR_W'(i);
            e.data = w;
            exp_q.push_back(e);
            for (int k = 0; k < 4; k++) begin
                ck = ck ^ w[8*k +: 8];
                send_byte(w[8*k +: 8]);
            end
        end
        send_byte(bad_ck ? ~ck : ck);
        rx_valid = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic h);
        check_eq({tag, "_done"},  64'(done),     64'(d));
        check_eq({tag, "_error"}, 64'(error),    64'(e));
        check_eq({tag, "_hold"},  64'(cpu_hold), 64'(h));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_we"},    64'(mem_we),    64'd0);
        check_eq({tag, "_addr"},  64'(mem_addr),  64'd0);
        check_eq({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
        check_eq({tag, "_rdy"},   64'(rx_ready),  64'd1);
        check_status(tag, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        // Two-word program, good checksum.
        words = '{32'h07800513, 32'h0C800293};
        send_frame(1'b0);
        check_status("two_word", 1'b1, 1'b0, 1'b0);
        check_eq("two_word_img0", 64'(img[0]), 64'h07800513);
        check_eq("two_word_img1", 64'(img[1]), 64'h0C800293);

        // Garbage ignored in DONE, then an empty frame.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        rx_valid = 1'b0;
        check_status("garbage", 1'b1, 1'b0, 1'b0);
        words.delete();
        send_frame(1'b0);
        check_status("empty", 1'b1, 1'b0, 1'b0);

        // One word with a corrupted checksum.
        words = '{32'hDEADBEEF};
        send_frame(1'b1);
        check_status("bad_ck", 1'b0, 1'b1, 1'b1);
        check_eq("bad_ck_img0", 64'(img[0]), 64'hDEADBEEF);

        // N = 257 is one word too many.
        send_byte(8'hA5);
        check_eq("restart_clears_error", 64'(error), 64'd0);
        send_byte(8'h01);
        send_byte(8'h01);
        rx_valid = 1'b0;
        check_status("too_long", 1'b0, 1'b1, 1'b1);
        words = '{32'h11223344, 32'h55667788};
        send_frame(1'b0);
        check_status("after_err", 1'b1, 1'b0, 1'b0);

        // Full-capacity load, back-to-back bytes.
        words.delete();
        for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
        send_frame(1'b0);
        check_status("full", 1'b1, 1'b0, 1'b0);
        check_eq("full_img0",   64'(img[0]),       64'(words[0]));
        check_eq("full_imglast", 64'(img[DEPTH-1]), 64'(words[DEPTH-1]));

        // Short back-to-back frame; compare the memory image.
        words.delete();
        for (int i = 0; i < 5; i++) words.push_back($urandom);
        send_frame(1'b0);
        check_status("b2b", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) check_eq("b2b_img", 64'(img[i]), 64'(words[i]));

        // Reset after the second payload byte abandons the frame.
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        rx_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        check_eq("mid_reset_pending", 64'(exp_q.size()), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        words = '{32'hCAFEF00D, 32'h0BADC0DE};
        send_frame(1'b0);
        check_status("post_reset", 1'b1, 1'b0, 1'b0);
        check_eq("post_reset_img0", 64'(img[0]), 64'hCAFEF00D);
        check_eq("post_reset_img1", 64'(img[1]), 64'h0BADC0DE);

        repeat (3) @(negedge clk);
        check_eq("pending_writes", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
